// File: rtl/traffic_light_fsm.sv
// Traffic light controller: main/side road phases with all-red clearance and
// a pedestrian walk phase inserted after whichever all-red follows a request.
module traffic_light_fsm #(
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1,
  parameter int WALK_S   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       walk,
  output logic       ped_ack,
  output logic [7:0] sec_left
);

  // state | meaning
  // MG    | main green, side red
  // MY    | main yellow, side red
  // AR1   | all red after main phase
  // SG    | side green, main red
  // SY    | side yellow, main red
  // AR2   | all red after side phase
  // WALK  | all red, pedestrian walk lamp on
  typedef enum logic [2:0] {MG, MY, AR1, SG, SY, AR2, WALK} state_t;

  localparam logic [7:0] LD_G = 8'(GREEN_S - 1);
  localparam logic [7:0] LD_Y = 8'(YELLOW_S - 1);
  localparam logic [7:0] LD_A = 8'(ALLRED_S - 1);
  localparam logic [7:0] LD_W = 8'(WALK_S - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       pending;
  logic       ped_q;
  logic       dir_side;
  logic       ped_rise;
  logic       expire;
  logic       go_walk;

  assign ped_rise = ped_req & ~ped_q;
  assign expire   = tick && (cnt == 8'd0);
  assign go_walk  = expire && pending && ((state == AR1) || (state == AR2));
  assign sec_left = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MG;
      cnt      <= LD_G;
      pending  <= 1'b0;
      ped_q    <= 1'b0;
      dir_side <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      ped_q   <= ped_req;
      ped_ack <= go_walk;
      // Clearing on WALK entry wins over an edge arriving in the same cycle.
      if (go_walk)
        pending <= 1'b0;
      else if (ped_rise)
        pending <= 1'b1;

      if (expire) begin
        case (state)
          MG:  begin state <= MY;  cnt <= LD_Y; end
          MY:  begin state <= AR1; cnt <= LD_A; end
          AR1: begin
            if (pending) begin
              state <= WALK; cnt <= LD_W; dir_side <= 1'b1;
            end else begin
              state <= SG;   cnt <= LD_G;
            end
          end
          SG:  begin state <= SY;  cnt <= LD_Y; end
          SY:  begin state <= AR2; cnt <= LD_A; end
          AR2: begin
            if (pending) begin
              state <= WALK; cnt <= LD_W; dir_side <= 1'b0;
            end else begin
              state <= MG;   cnt <= LD_G;
            end
          end
          WALK: begin
            state <= dir_side ? SG : MG;
            cnt   <= LD_G;
          end
          default: begin state <= MG; cnt <= LD_G; end
        endcase
      end else if (tick) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  always_comb begin
    main_r = 1'b0;
    main_y = 1'b0;
    main_g = 1'b0;
    side_r = 1'b0;
    side_y = 1'b0;
    side_g = 1'b0;
    walk   = 1'b0;
    case (state)
      MG:       begin main_g = 1'b1; side_r = 1'b1; end
      MY:       begin main_y = 1'b1; side_r = 1'b1; end
      SG:       begin main_r = 1'b1; side_g = 1'b1; end
      SY:       begin main_r = 1'b1; side_y = 1'b1; end
      AR1, AR2: begin main_r = 1'b1; side_r = 1'b1; end
      WALK:     begin main_r = 1'b1; side_r = 1'b1; walk = 1'b1; end
      default:  begin main_r = 1'b1; side_r = 1'b1; end
    endcase
  end

endmodule
